avalon_reg_master: RTL and testbench
====================================

Name: avalon_reg_master

Overview:
- Avalon-MM master (initiator) that drives register read/write transactions into the small CSR slaves on the SOPC fabric, e.g. the PLL status/control slave.
- Accepts one command at a time over a valid/ready handshake and runs a single Avalon-MM transfer, honouring waitrequest and a fixed read latency.
- Returns a one-cycle response carrying the read data and a timeout flag.
- Used by board bring-up logic to program slaves without a NIOS processor.

Parameters:
- ADDR_W, 3, Avalon address width (word address).
- DATA_W, 16, Avalon data width.
- READ_LATENCY, 0, cycles after the waitrequest-low cycle at which av_readdata is valid (0..7).
- TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles before the transfer is aborted (1..65535; only used with TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target word address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transfer aborted by timeout; qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- av_address  out  ADDR_W  Avalon address.
- av_chipselect  out  1  Avalon chipselect.
- av_read  out  1  Avalon read strobe.
- av_write  out  1  Avalon write strobe.
- av_writedata  out  DATA_W  Avalon write data.
- av_readdata  in  DATA_W  Avalon read data.
- av_waitrequest  in  1  slave stall; tie to 0 for slaves without waitrequest.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State is IDLE, counters are 0.
- All outputs are registered. Reset is sampled only on the rising edge of clk.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge T, latch address, write data and direction, then go to ACCESS.
- ACCESS, entered at T+1:
  - av_chipselect = 1, plus av_read or av_write per the latched direction.
  - av_address and av_writedata are held constant for the whole state.
  - Strobes stay asserted while av_waitrequest = 1.
  - On the first cycle with av_waitrequest = 0, the transfer completes. Strobes drop at the next edge.
    - Write: go to RESP.
    - Read with READ_LATENCY = 0: capture av_readdata in that same cycle, then go to RESP.
    - Read with READ_LATENCY > 0: go to RDWAIT.
- RDWAIT:
  - Strobes are low.
  - Counts READ_LATENCY cycles and captures av_readdata on the READ_LATENCY-th cycle after the completing cycle, then goes to RESP.
  - No timeout applies here.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_timeout valid.
  - Next state is IDLE; cmd_ready returns to 1 one cycle after rsp_valid.
- Minimum latency, write or READ_LATENCY = 0 read with no wait: accept at T, strobe at T+1, rsp_valid at T+2, cmd_ready at T+3.
- cmd_ready is low from T+1 through RESP. cmd_valid is ignored while busy, and commands are never queued.
- A read response always carries rsp_rdata equal to the captured value. A write response carries rsp_rdata = 0.
- Reset mid-transfer:
  - Strobes are low and the state is IDLE after the reset edge.
  - No rsp_valid is issued for the aborted command.
- av_waitrequest changing while the master is not in ACCESS is ignored.

Optional Feature:
- Macro AVALON_REG_MASTER_TIMEOUT_EN.
- When defined:
  - A 16-bit counter increments on each ACCESS cycle with av_waitrequest = 1, and clears on entry to ACCESS.
  - When the counter reaches TIMEOUT_CYCLES while waitrequest is still high, strobes drop at the next edge and the FSM enters RESP.
  - In that response, rsp_timeout = 1 and rsp_rdata = 0.
- When undefined:
  - No counter is built and the master waits indefinitely.
  - rsp_timeout is tied to 0.

Test Plan:
- Write 0x0003 to address 1, waitrequest = 0 → av_write && av_chipselect high for exactly 1 cycle at T+1 with address 1 and writedata 0x0003. rsp_valid at T+2 with rsp_rdata = 0 and rsp_timeout = 0.
- Read address 0, slave returns 0xA5C3, READ_LATENCY = 0 → av_read high 1 cycle, rsp_valid at T+2 with rsp_rdata = 0xA5C3.
- Read with waitrequest high for 4 cycles, READ_LATENCY = 2, slave drives 0x1234 two cycles after waitrequest falls → strobes held for 5 cycles with a stable address, rsp_rdata = 0x1234, rsp_valid 3 cycles after the completing cycle.
- cmd_valid held high continuously for 3 back-to-back writes → exactly one transfer per accepted command, accepts spaced 3 cycles apart, cmd_ready low while busy.
- With AVALON_REG_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and waitrequest stuck at 1 → strobes high for 8 cycles, then rsp_valid with rsp_timeout = 1 and rsp_rdata = 0. The next command is accepted normally.
- reset asserted for 1 cycle while in ACCESS with waitrequest = 1 → next cycle av_read, av_write and av_chipselect = 0, cmd_ready = 1, no rsp_valid.

Source files
------------

// File: rtl/avalon_reg_master.sv
// rtl/avalon_reg_master.sv - single-transfer Avalon-MM register master (optional timeout: AVALON_REG_MASTER_TIMEOUT_EN)
module avalon_reg_master #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 16,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_chipselect,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest
);

  // Reject configurations the latency counter or timeout counter cannot represent.
  if (READ_LATENCY < 0 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("avalon_reg_master: READ_LATENCY or TIMEOUT_CYCLES out of range");
  end

  // A zero-latency read completes straight from ACCESS; otherwise RDWAIT ends on LAT_LAST.
  localparam bit            NO_RDWAIT = (READ_LATENCY == 0);
  localparam logic [2:0]    LAT_LAST  = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [2:0]          r_lat_cnt;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_timeout;
  logic                r_av_chipselect;
  logic                r_av_read;
  logic                r_av_write;
  logic [ADDR_W-1:0]   r_av_address;
  logic [DATA_W-1:0]   r_av_writedata;
  logic                w_accept;
  logic                w_write_nxt;
  logic                w_capture;
  logic                w_timeout_hit;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_write_nxt = w_accept ? cmd_write : r_write;

`ifdef AVALON_REG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_to_cnt;

  // Count stalled ACCESS cycles; the count is zero whenever ACCESS is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state != S_ACCESS) begin
      r_to_cnt <= '0;
    end else if (av_waitrequest) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Abort at the end of the TIMEOUT_CYCLES-th stalled cycle.
  assign w_timeout_hit = (r_state == S_ACCESS) && av_waitrequest && (r_to_cnt == TO_LAST);
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Next-state decode and read-data capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!av_waitrequest) begin
          if (r_write || NO_RDWAIT) begin
            w_state_nxt = S_RESP;
            w_capture   = !r_write;
          end else begin
            w_state_nxt = S_RDWAIT;
          end
        end else if (w_timeout_hit) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RDWAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = S_RESP;
          w_capture   = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched command and every output registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_write         <= 1'b0;
      r_lat_cnt       <= '0;
      r_cmd_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_timeout   <= 1'b0;
      r_av_chipselect <= 1'b0;
      r_av_read       <= 1'b0;
      r_av_write      <= 1'b0;
      r_av_address    <= '0;
      r_av_writedata  <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_write         <= w_write_nxt;
      r_lat_cnt       <= (r_state == S_RDWAIT) ? r_lat_cnt + 3'd1 : 3'd0;
      r_cmd_ready     <= (w_state_nxt == S_IDLE);
      r_busy          <= (w_state_nxt != S_IDLE);
      r_rsp_valid     <= (w_state_nxt == S_RESP);
      r_rsp_rdata     <= (w_state_nxt == S_RESP && w_capture) ? av_readdata : '0;
      r_rsp_timeout   <= (w_state_nxt == S_RESP) && w_timeout_hit;
      r_av_chipselect <= (w_state_nxt == S_ACCESS);
      r_av_read       <= (w_state_nxt == S_ACCESS) && !w_write_nxt;
      r_av_write      <= (w_state_nxt == S_ACCESS) && w_write_nxt;
      if (w_accept) begin
        r_av_address   <= cmd_addr;
        r_av_writedata <= cmd_wdata;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_timeout   = r_rsp_timeout;
  assign av_chipselect = r_av_chipselect;
  assign av_read       = r_av_read;
  assign av_write      = r_av_write;
  assign av_address    = r_av_address;
  assign av_writedata  = r_av_writedata;

endmodule

// File: tb/tb_avalon_reg_master.sv
// tb/tb_avalon_reg_master.sv - directed self-checking bench for avalon_reg_master
module tb_avalon_reg_master;

  logic        clk = 1'b0;
  logic        reset;

  // DUT A: READ_LATENCY = 2, TIMEOUT_CYCLES = 8
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout, busy;
  logic [15:0] rsp_rdata;
  logic [2:0]  av_address;
  logic        av_chipselect, av_read, av_write;
  logic [15:0] av_writedata, av_readdata;
  logic        av_waitrequest;

  // DUT B: READ_LATENCY = 0
  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [2:0]  b_cmd_addr;
  logic [15:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_timeout, b_busy;
  logic [15:0] b_rsp_rdata;
  logic [2:0]  b_av_address;
  logic        b_av_chipselect, b_av_read, b_av_write;
  logic [15:0] b_av_writedata, b_av_readdata;
  logic        b_av_waitrequest;

  // flags: {cmd_ready, busy, rsp_valid, rsp_timeout, av_chipselect, av_read, av_write}
  logic [6:0]  a_flags, b_flags;
  assign a_flags = {cmd_ready, busy, rsp_valid, rsp_timeout, av_chipselect, av_read, av_write};
  assign b_flags = {b_cmd_ready, b_busy, b_rsp_valid, b_rsp_timeout, b_av_chipselect, b_av_read, b_av_write};

  localparam logic [6:0] F_IDLE  = 7'b1000000;
  localparam logic [6:0] F_WR    = 7'b0100101;
  localparam logic [6:0] F_RD    = 7'b0100110;
  localparam logic [6:0] F_BUSY  = 7'b0100000;
  localparam logic [6:0] F_RESP  = 7'b0110000;
  localparam logic [6:0] F_RESPT = 7'b0111000;

  int errors = 0;
  int checks = 0;

  avalon_reg_master #(.ADDR_W(3), .DATA_W(16), .READ_LATENCY(2), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  avalon_reg_master #(.ADDR_W(3), .DATA_W(16), .READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_timeout(b_rsp_timeout), .busy(b_busy),
    .av_address(b_av_address), .av_chipselect(b_av_chipselect), .av_read(b_av_read),
    .av_write(b_av_write), .av_writedata(b_av_writedata), .av_readdata(b_av_readdata),
    .av_waitrequest(b_av_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; av_readdata = 0; av_waitrequest = 0;
    b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_wdata = 0; b_av_readdata = 0; b_av_waitrequest = 0;
    repeat (3) step();
    reset = 1'b0;
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL reset_a_flags: got %b expected %b", a_flags, F_IDLE); end
    checks++; if (b_flags !== F_IDLE) begin errors++; $display("FAIL reset_b_flags: got %b expected %b", b_flags, F_IDLE); end
    checks++; if ({rsp_rdata, av_writedata, av_address} !== 35'h0) begin errors++; $display("FAIL reset_a_data: got rdata=%h wdata=%h addr=%h expected 0", rsp_rdata, av_writedata, av_address); end
    step();
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL reset_idle_hold: got %b expected %b", a_flags, F_IDLE); end
  endtask

  task automatic test_write();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd1; cmd_wdata = 16'h0003; av_waitrequest = 0;
    step();
    cmd_valid = 0; cmd_wdata = 16'hFFFF; cmd_addr = 3'd7;
    checks++; if (a_flags !== F_WR) begin errors++; $display("FAIL write_strobe: got %b expected %b", a_flags, F_WR); end
    checks++; if (av_address !== 3'd1) begin errors++; $display("FAIL write_addr: got %h expected 1", av_address); end
    checks++; if (av_writedata !== 16'h0003) begin errors++; $display("FAIL write_wdata: got %h expected 0003", av_writedata); end
    step();
    checks++; if (a_flags !== F_RESP) begin errors++; $display("FAIL write_resp: got %b expected %b", a_flags, F_RESP); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL write_rdata: got %h expected 0000", rsp_rdata); end
    step();
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL write_ready_back: got %b expected %b", a_flags, F_IDLE); end
  endtask

  task automatic test_read_lat0();
    b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = 3'd0; b_av_waitrequest = 0;
    step();
    b_cmd_valid = 0; b_av_readdata = 16'hA5C3;
    checks++; if (b_flags !== F_RD) begin errors++; $display("FAIL rd0_strobe: got %b expected %b", b_flags, F_RD); end
    checks++; if (b_av_address !== 3'd0) begin errors++; $display("FAIL rd0_addr: got %h expected 0", b_av_address); end
    step();
    b_av_readdata = 16'h0000;
    checks++; if (b_flags !== F_RESP) begin errors++; $display("FAIL rd0_resp: got %b expected %b", b_flags, F_RESP); end
    checks++; if (b_rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL rd0_rdata: got %h expected a5c3", b_rsp_rdata); end
    step();
    checks++; if (b_flags !== F_IDLE) begin errors++; $display("FAIL rd0_idle: got %b expected %b", b_flags, F_IDLE); end
  endtask

  task automatic test_read_wait_latency();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd5; av_readdata = 16'hDEAD;
    step();
    cmd_valid = 0; cmd_addr = 3'd2;
    for (int i = 0; i < 5; i++) begin
      av_waitrequest = (i < 4);
      checks++; if (a_flags !== F_RD) begin errors++; $display("FAIL rdw_strobe_%0d: got %b expected %b", i, a_flags, F_RD); end
      checks++; if (av_address !== 3'd5) begin errors++; $display("FAIL rdw_addr_%0d: got %h expected 5", i, av_address); end
      step();
    end
    av_waitrequest = 1;
    checks++; if (a_flags !== F_BUSY) begin errors++; $display("FAIL rdw_lat1: got %b expected %b", a_flags, F_BUSY); end
    step();
    av_readdata = 16'h1234;
    checks++; if (a_flags !== F_BUSY) begin errors++; $display("FAIL rdw_lat2: got %b expected %b", a_flags, F_BUSY); end
    step();
    av_readdata = 16'h0000; av_waitrequest = 0;
    checks++; if (a_flags !== F_RESP) begin errors++; $display("FAIL rdw_resp: got %b expected %b", a_flags, F_RESP); end
    checks++; if (rsp_rdata !== 16'h1234) begin errors++; $display("FAIL rdw_rdata: got %h expected 1234", rsp_rdata); end
    step();
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL rdw_idle: got %b expected %b", a_flags, F_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_f;
    int         writes = 0;
    cmd_valid = 1; cmd_write = 1; av_waitrequest = 0;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) begin
        cmd_addr = 3'(k / 3 + 2); cmd_wdata = 16'(16'h0100 + k / 3);
      end
      exp_f = (k % 3 == 0) ? F_IDLE : (k % 3 == 1) ? F_WR : F_RESP;
      checks++; if (a_flags !== exp_f) begin errors++; $display("FAIL b2b_flags_%0d: got %b expected %b", k, a_flags, exp_f); end
      if (av_write) writes++;
      if (k % 3 == 1) begin
        checks++; if ({av_address, av_writedata} !== {3'(k / 3 + 2), 16'(16'h0100 + k / 3)}) begin
          errors++; $display("FAIL b2b_data_%0d: got addr=%h wdata=%h expected addr=%h wdata=%h", k, av_address, av_writedata, k / 3 + 2, 16'h0100 + k / 3);
        end
      end
      step();
    end
    cmd_valid = 0;
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL b2b_end_ready: got %b expected %b", a_flags, F_IDLE); end
    step();
    if (av_write) writes++;
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL b2b_no_extra: got %b expected %b", a_flags, F_IDLE); end
    checks++; if (writes !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", writes); end
  endtask

  task automatic test_timeout();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd6; av_waitrequest = 1; av_readdata = 16'h0BEE;
    step();
    cmd_valid = 0;
`ifdef AVALON_REG_MASTER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_flags !== F_RD) begin errors++; $display("FAIL to_strobe_%0d: got %b expected %b", i, a_flags, F_RD); end
      step();
    end
    checks++; if (a_flags !== F_RESPT) begin errors++; $display("FAIL to_resp: got %b expected %b", a_flags, F_RESPT); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0000", rsp_rdata); end
    av_waitrequest = 0;
    step();
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL to_idle: got %b expected %b", a_flags, F_IDLE); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd4; cmd_wdata = 16'h0055;
    step();
    cmd_valid = 0;
    checks++; if (a_flags !== F_WR) begin errors++; $display("FAIL to_next_strobe: got %b expected %b", a_flags, F_WR); end
    step();
    checks++; if (a_flags !== F_RESP) begin errors++; $display("FAIL to_next_resp: got %b expected %b", a_flags, F_RESP); end
    step();
`else
    for (int i = 0; i < 12; i++) begin
      checks++; if (a_flags !== F_RD) begin errors++; $display("FAIL nto_strobe_%0d: got %b expected %b", i, a_flags, F_RD); end
      step();
    end
    av_waitrequest = 0;
    step();
    step();
    step();
    checks++; if (a_flags !== F_RESP) begin errors++; $display("FAIL nto_resp: got %b expected %b", a_flags, F_RESP); end
    checks++; if (rsp_rdata !== 16'h0BEE) begin errors++; $display("FAIL nto_rdata: got %h expected 0bee", rsp_rdata); end
    step();
`endif
    av_readdata = 16'h0000;
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd3; av_waitrequest = 1;
    step();
    cmd_valid = 0;
    checks++; if (a_flags !== F_RD) begin errors++; $display("FAIL rst_mid_access: got %b expected %b", a_flags, F_RD); end
    step();
    reset = 1;
    step();
    reset = 0;
    checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL rst_mid_after: got %b expected %b", a_flags, F_IDLE); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_flags !== F_IDLE) begin errors++; $display("FAIL rst_mid_quiet_%0d: got %b expected %b", i, a_flags, F_IDLE); end
    end
    av_waitrequest = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_lat0();
    test_read_wait_latency();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
